mini_fir_seq: RTL and testbench

//  Time-multiplexed FIR sequencer: drives one multiply-accumulate datapath over TAPS cycles per sample.

---
 rtl/mini_fir_seq_pkg.sv | 20 ++
 rtl/mini_fir_seq_step.sv | 18 +
 rtl/mini_fir_seq.sv | 118 +++++++++++
 tb/tb_mini_fir_seq.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mini_fir_seq_pkg.sv
// Shared definitions for the time-multiplexed FIR sequencer: default widths,
// the accumulator-width formula and the sequencer state encoding.
package mini_fir_seq_pkg;

    localparam int DW_DEF   = 8;
    localparam int CW_DEF   = 8;
    localparam int TAPS_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Enough headroom for TAPS products of full-scale operands, so the sum never wraps.
    function automatic int accw_f(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

endpackage

// File: rtl/mini_fir_seq_step.sv
// One multiply-accumulate step: acc_out = acc_in + x*c, purely combinational.
module mini_fir_step #(
    parameter int DW   = 8,
    parameter int CW   = 8,
    parameter int ACCW = 19
) (
    input  logic [ACCW-1:0] acc_in,
    input  logic [DW-1:0]   x,
    input  logic [CW-1:0]   c,
    output logic [ACCW-1:0] acc_out
);

    logic [DW+CW-1:0] prod;

    assign prod    = {{CW{1'b0}}, x} * {{DW{1'b0}}, c};
    assign acc_out = acc_in + {{(ACCW-DW-CW){1'b0}}, prod};

endmodule

// File: rtl/mini_fir_seq.sv
// FIR sequencer sharing one MAC over TAPS cycles per sample, with a circular
// delay line and writable coefficient bank. MINI_FIR_COEFF_RD_EN adds coefficient readback.
module mini_fir_seq
    import mini_fir_seq_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int CW   = CW_DEF,
    parameter int TAPS = TAPS_DEF,
    parameter int AW   = $clog2(TAPS),
    parameter int ACCW = accw_f(DW, CW, TAPS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [DW-1:0]   i_data,
    input  logic            i_cwe,
    input  logic [AW-1:0]   i_caddr,
    input  logic [CW-1:0]   i_cdata,
    output logic            o_cerr,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [ACCW-1:0] o_data
`ifdef MINI_FIR_COEFF_RD_EN
    ,
    input  logic [AW-1:0]   i_craddr,
    output logic [CW-1:0]   o_crdata
`endif
);

    localparam logic [AW:0]   TAPS_W = (AW+1)'(TAPS);
    localparam logic [AW-1:0] LAST   = AW'(TAPS-1);

    state_t          state;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   k;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] acc_nxt;
    logic [DW-1:0]   xline [TAPS];
    logic [CW-1:0]   coef  [TAPS];
    logic            cw_ok;

    assign i_ready = (state == ST_IDLE);
    assign o_valid = (state == ST_DONE);

    // Writes are only safe while no sample is in flight and the index is in the bank.
    assign cw_ok = (state == ST_IDLE) && ({1'b0, i_caddr} < TAPS_W);

    mini_fir_step #(
        .DW   (DW),
        .CW   (CW),
        .ACCW (ACCW)
    ) u_step (
        .acc_in  (acc),
        .x       (xline[rd_ptr]),
        .c       (coef[k]),
        .acc_out (acc_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            k      <= '0;
            acc    <= '0;
            o_data <= '0;
            o_cerr <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                xline[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            o_cerr <= i_cwe && !cw_ok;
            if (i_cwe && cw_ok)
                coef[i_caddr] <= i_cdata;

            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        xline[wr_ptr] <= i_data;
                        acc           <= '0;
                        rd_ptr        <= wr_ptr;
                        k             <= '0;
                        wr_ptr        <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                        state         <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Walk newest to oldest sample while the tap index climbs.
                    acc    <= acc_nxt;
                    rd_ptr <= (rd_ptr == '0) ? LAST : rd_ptr - 1'b1;
                    k      <= k + 1'b1;
                    if (k == LAST) begin
                        o_data <= acc_nxt;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (o_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MINI_FIR_COEFF_RD_EN
    always_ff @(posedge clk) begin
        if (rst)
            o_crdata <= '0;
        else
            o_crdata <= ({1'b0, i_craddr} < TAPS_W) ? coef[i_craddr] : '0;
    end
`endif

endmodule

// File: tb/tb_mini_fir_seq.sv
// Randomised self-checking bench for mini_fir_seq against a sum-of-products model
// over the full sample history; a second TAPS=6 instance covers out-of-range writes.
module tb_mini_fir_seq;

    localparam int DW   = 8;
    localparam int CW   = 8;
    localparam int TAPS = 8;
    localparam int AW   = 3;
    localparam int ACCW = 19;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_valid = 1'b0;
    logic [DW-1:0]   i_data = '0;
    logic            i_cwe = 1'b0;
    logic [AW-1:0]   i_caddr = '0;
    logic [CW-1:0]   i_cdata = '0;
    logic            o_ready = 1'b1;
    logic            i_ready, o_valid, o_cerr;
    logic [ACCW-1:0] o_data;
    logic            r6, v6, e6;
    logic [ACCW-1:0] d6;
`ifdef MINI_FIR_COEFF_RD_EN
    logic [AW-1:0]   i_craddr = '0;
    logic [CW-1:0]   o_crdata, crd6;
`endif

    int checks = 0;
    int failures = 0;
    int coef_m[TAPS];
    int hist[$];

    always #5 clk = ~clk;

    mini_fir_seq #(.DW(DW), .CW(CW), .TAPS(TAPS)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
        .i_cwe(i_cwe), .i_caddr(i_caddr), .i_cdata(i_cdata), .o_cerr(o_cerr),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data)
`ifdef MINI_FIR_COEFF_RD_EN
        , .i_craddr(i_craddr), .o_crdata(o_crdata)
`endif
    );

    mini_fir_seq #(.DW(DW), .CW(CW), .TAPS(6)) dut6 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(r6), .i_data(i_data),
        .i_cwe(i_cwe), .i_caddr(i_caddr), .i_cdata(i_cdata), .o_cerr(e6),
        .o_valid(v6), .o_ready(o_ready), .o_data(d6)
`ifdef MINI_FIR_COEFF_RD_EN
        , .i_craddr(i_craddr), .o_crdata(crd6)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < TAPS; i++) coef_m[i] = 0;
    endtask

    function automatic int model_y();
        int s = 0;
        for (int t = 0; t < TAPS; t++)
            if (t < hist.size()) s += coef_m[t] * hist[hist.size()-1-t];
        return s;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic write_coef(input int a, input int d);
        i_cwe = 1'b1; i_caddr = AW'(a); i_cdata = CW'(d);
        tick();
        i_cwe = 1'b0;
        if (a < TAPS) coef_m[a] = d;
        chk("cerr_idle_wr", int'(o_cerr), 0);
    endtask

    task automatic run_sample(input int x, input int hold, input bit cwe_run,
                              input bit same_wr, input int wa, input int wd, output int y);
        int n, exp;
        n = 0;
        o_ready = (hold == 0);
        while (!i_ready && n < 50) begin tick(); n++; end
        chk("ready_before", int'(i_ready), 1);
        i_valid = 1'b1; i_data = DW'(x);
        if (same_wr) begin
            i_cwe = 1'b1; i_caddr = AW'(wa); i_cdata = CW'(wd);
            coef_m[wa] = wd;
        end
        tick();
        i_valid = 1'b0; i_cwe = 1'b0;
        if (same_wr) chk("cerr_same_wr", int'(o_cerr), 0);
        hist.push_back(x);
        exp = model_y();
        chk("ready_in_run", int'(i_ready), 0);
        n = 0;
        if (cwe_run) begin
            i_cwe = 1'b1; i_caddr = AW'($urandom_range(0, TAPS-1)); i_cdata = CW'($urandom);
            tick(); n++;
            i_cwe = 1'b0;
            chk("cerr_run", int'(o_cerr), 1);
            tick(); n++;
            chk("cerr_pulse", int'(o_cerr), 0);
        end
        while (!o_valid && n < 50) begin tick(); n++; end
        chk("latency", n + 1, TAPS + 1);
        chk("o_data", int'(o_data), exp);
        y = int'(o_data);
        for (int h = 0; h < hold; h++) begin
            i_valid = 1'b1; i_data = DW'($urandom);
            tick();
            chk("bp_valid", int'(o_valid), 1);
            chk("bp_data", int'(o_data), exp);
            chk("bp_ready", int'(i_ready), 0);
        end
        i_valid = 1'b0; o_ready = 1'b1;
        tick();
        chk("handshake", int'(o_valid), 0);
        chk("idle_ready", int'(i_ready), 1);
        chk("idle_hold", int'(o_data), exp);
    endtask

    initial begin
        int y, n, any_v;
        int t1_exp[10] = '{1, 2, 3, 4, 5, 6, 7, 8, 0, 0};

        do_reset();
        chk("rst_ready", int'(i_ready), 1);
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_data", int'(o_data), 0);
        chk("rst_cerr", int'(o_cerr), 0);

        // Out-of-range index on the 6-tap instance is dropped; the 8-tap one accepts it.
        write_coef(0, 3);
        i_cwe = 1'b1; i_caddr = AW'(6); i_cdata = CW'(7);
        tick();
        i_cwe = 1'b0; coef_m[6] = 7;
        chk("cerr6_oob", int'(e6), 1);
        chk("cerr8_inb", int'(o_cerr), 0);
        tick();
        chk("cerr6_pulse", int'(e6), 0);
        i_valid = 1'b1; i_data = DW'(2);
        tick();
        i_valid = 1'b0; hist.push_back(2);
        n = 0;
        while (!v6 && n < 50) begin tick(); n++; end
        chk("lat6", n + 1, 7);
        chk("data6", int'(d6), 6);
        while (!o_valid && n < 50) begin tick(); n++; end
        chk("data8_c6", int'(o_data), model_y());
        tick();

        // T1 impulse
        do_reset();
        for (int i = 0; i < TAPS; i++) write_coef(i, i + 1);
        for (int i = 0; i < 10; i++) begin
            run_sample((i == 0) ? 1 : 0, 0, 1'b0, 1'b0, 0, 0, y);
            chk("t1_impulse", y, t1_exp[i]);
        end

        // T2 full scale
        for (int i = 0; i < TAPS; i++) write_coef(i, 255);
        for (int i = 0; i < TAPS; i++) run_sample(255, 0, 1'b0, 1'b0, 0, 0, y);
        chk("t2_max", y, 520200);

        // T3 backpressure, T4 write during RUN
        run_sample(17, 5, 1'b0, 1'b0, 0, 0, y);
        run_sample(99, 0, 1'b1, 1'b0, 0, 0, y);
        run_sample(3, 0, 1'b0, 1'b0, 0, 0, y);

        // Write and accept in the same cycle
        run_sample(40, 0, 1'b0, 1'b1, 0, 11, y);

        // T5 reset mid-RUN
        i_valid = 1'b1; i_data = DW'($urandom_range(1, 255));
        tick();
        i_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("t5_valid", int'(o_valid), 0);
        chk("t5_ready", int'(i_ready), 1);
        chk("t5_data", int'(o_data), 0);
        any_v = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_valid) any_v = 1;
        end
        chk("t5_no_valid", any_v, 0);
        write_coef(0, 3);
        run_sample(1, 0, 1'b0, 1'b0, 0, 0, y);
        chk("t5_result", y, 3);

`ifdef MINI_FIR_COEFF_RD_EN
        // T6 readback
        write_coef(5, 8'hA5);
        i_craddr = AW'(5);
        tick();
        chk("t6_rd8", int'(o_crdata), 8'hA5);
        chk("t6_rd6", int'(crd6), 8'hA5);
        i_craddr = AW'(7);
        tick();
        chk("t6_rd8_7", int'(o_crdata), coef_m[7]);
        chk("t6_rd6_oob", int'(crd6), 0);
`endif

        // Randomised traffic
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0)
                write_coef($urandom_range(0, TAPS-1), $urandom_range(0, 255));
            run_sample($urandom_range(0, 255), $urandom_range(0, 2),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                       $urandom_range(0, TAPS-1), $urandom_range(0, 255), y);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
